// File: rtl/mem_handshake_ram_if.sv
// Memory request/response bundle between the datapath/control unit and the RAM.
// MOV/MOC form a four-phase handshake; the remaining signals qualify the request.
interface mem_handshake_ram_if;
    logic        MOV;
    logic        RW;
    logic [1:0]  Size;
    logic        SignExt;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        Misalign;

    modport master (
        output MOV, RW, Size, SignExt, Address, DataIn,
        input  DataOut, MOC, Misalign
    );

    modport slave (
        input  MOV, RW, Size, SignExt, Address, DataIn,
        output DataOut, MOC, Misalign
    );
endinterface

// File: rtl/mem_handshake_ram.sv
// Byte-addressable big-endian RAM with byte/half/word access and load extension.
// Latency: WAIT_CYCLES+1 edges from MOV sampled to MOC; misaligned requests complete after 1 edge.
// Backpressure: one outstanding op; MOC holds until MOV drops, which is required before the next request.
module mem_handshake_ram #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH_BYTES = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_handshake_ram_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               rw_q;
    logic               sext_q;
    logic [1:0]         size_q;
    logic [31:0]        din_q;
    logic [31:0]        dout_q;
    logic               moc_q;
    logic               mis_q;

    logic [7:0]         mem [DEPTH_BYTES];

    logic               req_misaligned;
    logic               access;
    logic [31:0]        rd_data;
    logic [ADDR_W-1:0]  a1, a2, a3;

    assign a1 = addr_q + ADDR_W'(1);
    assign a2 = addr_q + ADDR_W'(2);
    assign a3 = addr_q + ADDR_W'(3);

    assign access = (state_q == BUSY) && (cnt_q == 4'd0);

    always_comb begin
        req_misaligned = 1'b0;
        case (bus.Size)
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = bus.Address[0];
            default: req_misaligned = |bus.Address[1:0];
        endcase
    end

    always_comb begin
        rd_data = 32'd0;
        case (size_q)
            2'b00:   rd_data = {{24{sext_q & mem[addr_q][7]}}, mem[addr_q]};
            2'b01:   rd_data = {{16{sext_q & mem[addr_q][7]}}, mem[addr_q], mem[a1]};
            default: rd_data = {mem[addr_q], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.MOV) state_d = req_misaligned ? DONE : BUSY;
            BUSY: if (cnt_q == 4'd0) state_d = DONE;
            DONE: if (!bus.MOV) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            moc_q   <= 1'b0;
            mis_q   <= 1'b0;
            dout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.MOV) begin
                        addr_q <= bus.Address[ADDR_W-1:0];
                        rw_q   <= bus.RW;
                        size_q <= bus.Size;
                        sext_q <= bus.SignExt;
                        din_q  <= bus.DataIn;
                        cnt_q  <= WAIT_INIT;
                        if (req_misaligned) begin
                            moc_q  <= 1'b1;
                            mis_q  <= 1'b1;
                            dout_q <= 32'd0;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        moc_q <= 1'b1;
                        mis_q <= 1'b0;
                        if (rw_q) dout_q <= rd_data;
                    end
                end
                DONE: begin
                    if (!bus.MOV) begin
                        moc_q <= 1'b0;
                        mis_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array is never cleared; reset only suppresses a write whose access edge coincides with it.
    always_ff @(posedge clk) begin
        if (reset && access && !rw_q) begin
            case (size_q)
                2'b00: mem[addr_q] <= din_q[7:0];
                2'b01: begin
                    mem[addr_q] <= din_q[15:8];
                    mem[a1]     <= din_q[7:0];
                end
                default: begin
                    mem[addr_q] <= din_q[31:24];
                    mem[a1]     <= din_q[23:16];
                    mem[a2]     <= din_q[15:8];
                    mem[a3]     <= din_q[7:0];
                end
            endcase
        end
    end

    assign bus.DataOut  = dout_q;
    assign bus.MOC      = moc_q;
    assign bus.Misalign = mis_q;

endmodule

// File: tb/tb_mem_handshake_ram.sv
// Scoreboard bench for mem_handshake_ram: stimulus pushes expected responses, a monitor checks each MOC rise.
module tb_mem_handshake_ram;

    typedef struct {
        logic [31:0] d;
        logic        m;
        int          lat;
        int          issue;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   moc_hi_cnt;
    logic moc_prev;
    exp_t sb[$];

    mem_handshake_ram_if mif ();

    mem_handshake_ram #(
        .ADDR_W(9), .DEPTH_BYTES(512), .WAIT_CYCLES(2)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: samples 1ns after each rising edge, pops one expectation per MOC rise.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst_n && mif.MOC && !moc_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_moc", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dataout", mif.DataOut, e.d);
                chk("misalign", {31'd0, mif.Misalign}, {31'd0, e.m});
                chk("latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
        if (mif.MOC) moc_hi_cnt++;
        moc_prev = mif.MOC;
    end

    task automatic issue(input logic rw, input logic [1:0] sz, input logic sx,
                         input logic [31:0] addr, input logic [31:0] din,
                         input logic [31:0] exp_d, input logic exp_m, input int exp_lat,
                         input bit push);
        exp_t e;
        @(negedge clk);
        mif.RW = rw; mif.Size = sz; mif.SignExt = sx;
        mif.Address = addr; mif.DataIn = din; mif.MOV = 1'b1;
        moc_hi_cnt = 0;
        if (push) begin
            e.d = exp_d; e.m = exp_m; e.lat = exp_lat; e.issue = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic wait_moc(input logic level, input string name);
        for (int i = 0; i < 40 && mif.MOC !== level; i++) @(negedge clk);
        chk(name, {31'd0, mif.MOC}, {31'd0, level});
    endtask

    task automatic op(input logic rw, input logic [1:0] sz, input logic sx,
                      input logic [31:0] addr, input logic [31:0] din,
                      input logic [31:0] exp_d, input logic exp_m, input int exp_lat);
        issue(rw, sz, sx, addr, din, exp_d, exp_m, exp_lat, 1'b1);
        wait_moc(1'b1, "moc_rise");
        mif.MOV = 1'b0;
        wait_moc(1'b0, "moc_fall");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; moc_hi_cnt = 0; moc_prev = 1'b0;
        rst_n = 1'b0;
        mif.MOV = 1'b1; mif.RW = 1'b1; mif.Size = 2'b10; mif.SignExt = 1'b0;
        mif.Address = 32'h10; mif.DataIn = 32'h0;

        // Reset held two edges with MOV asserted.
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_moc", {31'd0, mif.MOC}, 32'd0);
        chk("rst_misalign", {31'd0, mif.Misalign}, 32'd0);
        chk("rst_dataout", mif.DataOut, 32'd0);
        rst_n = 1'b1; mif.MOV = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("idle_moc", {31'd0, mif.MOC}, 32'd0);

        // rw, size, sext, addr, din, expected DataOut, misalign, latency
        op(1'b0, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0, 3);
        op(1'b1, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 3);
        op(1'b1, 2'b00, 1'b1, 32'h10,  32'h0,        32'hFFFFFFDE, 1'b0, 3);
        op(1'b1, 2'b00, 1'b1, 32'h11,  32'h0,        32'hFFFFFFAD, 1'b0, 3);
        op(1'b1, 2'b00, 1'b0, 32'h11,  32'h0,        32'h000000AD, 1'b0, 3);
        op(1'b1, 2'b01, 1'b1, 32'h12,  32'h0,        32'hFFFFBEEF, 1'b0, 3);
        op(1'b1, 2'b01, 1'b0, 32'h10,  32'h0,        32'h0000DEAD, 1'b0, 3);
        op(1'b0, 2'b00, 1'b0, 32'h13,  32'hAAAAAA7F, 32'h0000DEAD, 1'b0, 3);
        op(1'b1, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBE7F, 1'b0, 3);
        op(1'b1, 2'b10, 1'b0, 32'h12,  32'h0,        32'h00000000, 1'b1, 0);
        op(1'b0, 2'b01, 1'b0, 32'h13,  32'h00005555, 32'h00000000, 1'b1, 0);
        op(1'b1, 2'b01, 1'b1, 32'h11,  32'h0,        32'h00000000, 1'b1, 0);
        op(1'b1, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBE7F, 1'b0, 3);
        op(1'b0, 2'b10, 1'b0, 32'h14,  32'h00000000, 32'hDEADBE7F, 1'b0, 3);
        op(1'b0, 2'b01, 1'b0, 32'h16,  32'hFFFFCAFE, 32'hDEADBE7F, 1'b0, 3);
        op(1'b1, 2'b10, 1'b0, 32'h14,  32'h0,        32'h0000CAFE, 1'b0, 3);
        op(1'b1, 2'b01, 1'b1, 32'h16,  32'h0,        32'hFFFFCAFE, 1'b0, 3);
        op(1'b1, 2'b00, 1'b0, 32'h17,  32'h0,        32'h000000FE, 1'b0, 3);
        op(1'b1, 2'b10, 1'b0, 32'h210, 32'h0,        32'hDEADBE7F, 1'b0, 3);
        op(1'b1, 2'b10, 1'b0, 32'hFFFFFE10, 32'h0,   32'hDEADBE7F, 1'b0, 3);
        op(1'b1, 2'b11, 1'b0, 32'h10,  32'h0,        32'hDEADBE7F, 1'b0, 3);

        // MOV held high past MOC while inputs change: no second access.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBE7F, 1'b0, 3, 1'b1);
        wait_moc(1'b1, "hold_rise");
        mif.RW = 1'b0; mif.DataIn = 32'h11111111;
        moc_hi_cnt = 0;
        repeat (5) @(negedge clk);
        chk("hold_moc_cycles", 32'(moc_hi_cnt), 32'd5);
        chk("hold_moc_level", {31'd0, mif.MOC}, 32'd1);
        chk("hold_dataout", mif.DataOut, 32'hDEADBE7F);
        mif.MOV = 1'b0;
        wait_moc(1'b0, "hold_fall");
        op(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBE7F, 1'b0, 3);

        // MOV dropped during BUSY: access completes, MOC pulses for one cycle.
        issue(1'b1, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0000CAFE, 1'b0, 3, 1'b1);
        @(negedge clk);
        mif.MOV = 1'b0;
        repeat (8) @(negedge clk);
        chk("drop_moc_cycles", 32'(moc_hi_cnt), 32'd1);
        chk("drop_moc_level", {31'd0, mif.MOC}, 32'd0);

        // Reset during BUSY discards the pending write.
        op(1'b0, 2'b10, 1'b0, 32'h20, 32'h00000000, 32'h0000CAFE, 1'b0, 3);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_moc_a", {31'd0, mif.MOC}, 32'd0);
        @(negedge clk);
        chk("midrst_moc_b", {31'd0, mif.MOC}, 32'd0);
        mif.MOV = 1'b0; rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("midrst_moc_after", {31'd0, mif.MOC}, 32'd0);
        chk("midrst_dataout", mif.DataOut, 32'd0);
        op(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h00000000, 1'b0, 3);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_handshake_ram.md
Name: mem_handshake_ram

Overview:
- Byte-addressable, big-endian data/instruction memory that sits directly downstream of the datapath.
- Consumes the datapath's MAR address, MDR write data, RW and MOV (memory operation valid).
- Returns DataOut and the MOC (memory operation complete) handshake that the control unit waits on.
- Supports MIPS byte, halfword and word accesses, sign/zero extension on loads, a configurable wait-state count and misalignment flagging.

Parameters:
- ADDR_W, 9, number of byte-address bits used; Address is taken modulo 2^ADDR_W.
- DEPTH_BYTES, 512, storage size in bytes; must equal 2^ADDR_W.
- WAIT_CYCLES, 2, extra busy cycles before the access completes (0 allowed, max 15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- MOV  input  1  request valid; held high by the master until MOC is seen.
- RW  input  1  1 = read, 0 = write.
- Size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- SignExt  input  1  loads only: 1 sign-extends, 0 zero-extends byte/halfword results.
- Address  input  32  byte address; only [ADDR_W-1:0] used.
- DataIn  input  32  write data, right-justified for byte/halfword.
- DataOut  output  32  read data, extended per Size/SignExt.
- MOC  output  1  operation complete, four-phase handshake.
- Misalign  output  1  high with MOC when the request was misaligned.

Behaviour:
- Reset: when reset==0 at a clk edge:
  - state IDLE; MOC=0, Misalign=0, DataOut=0; wait counter=0.
  - Memory array contents are not cleared.
  - Reset overrides everything, including mid-operation: a pending write whose access edge has not occurred is discarded.
- States: IDLE, BUSY, DONE.
- IDLE:
  - At an edge with MOV=1, latch Address, RW, Size, SignExt and DataIn. Later input changes are ignored until return to IDLE.
  - Alignment rule: halfword needs A[0]=0; word (Size 10/11) needs A[1:0]=00.
  - Aligned request: counter=WAIT_CYCLES, go to BUSY.
  - Misaligned request: go to DONE with MOC=1, Misalign=1, DataOut=0, memory untouched.
- BUSY:
  - If counter!=0, decrement and stay in BUSY.
  - If counter==0, perform the access on this edge, set MOC=1, Misalign=0, go to DONE.
- Latency: MOV sampled at edge k gives MOC high after edge k+WAIT_CYCLES+1. Read data is valid in the same cycle MOC rises.
- DONE:
  - Hold MOC=1 and DataOut.
  - At an edge with MOV=0, go to IDLE and clear MOC and Misalign. DataOut holds its last value.
  - A new request needs MOV low for at least one sampled edge.
- MOV dropping during BUSY: the latched access still completes; MOC is then high for exactly one cycle before DONE sees MOV=0.
- Reads (a = latched address mod DEPTH_BYTES, m = byte array):
  - word = {m[a], m[a+1], m[a+2], m[a+3]}.
  - half = {m[a], m[a+1]}, extended to 32 bits.
  - byte = m[a], extended to 32 bits.
- Writes:
  - byte: m[a] = DataIn[7:0].
  - half: m[a] = DataIn[15:8], m[a+1] = DataIn[7:0].
  - word: m[a..a+3] = DataIn[31:24], [23:16], [15:8], [7:0].
  - Write cycles leave DataOut unchanged.
- Wrap-around: addresses above DEPTH_BYTES-1 alias modulo DEPTH_BYTES. Aligned accesses never straddle the array end.
- No simultaneous requests: single port, one outstanding operation.

Test Plan:
- Reset: hold reset=0 two edges with MOV=1 -> MOC=0, Misalign=0, DataOut=0, state IDLE; release reset with MOV=0 -> stays IDLE.
- Word write/read, WAIT_CYCLES=2: write 0xDEADBEEF to 0x10, then read word 0x10 -> MOC rises 3 edges after MOV sampled; DataOut=0xDEADBEEF; bytes 0x10..0x13 = DE, AD, BE, EF.
- Byte/half extension, continuing from the previous memory contents:
  - byte 0x11 signed -> 0xFFFFFFAD; byte 0x11 unsigned -> 0x000000AD.
  - half 0x12 signed -> 0xFFFFBEEF.
  - sb 0x7F to 0x13, then lw 0x10 -> 0xDEADBE7F.
- Misalignment: lw at 0x12 and sh at 0x13 -> MOC and Misalign high one edge after MOV; DataOut=0; lw 0x10 still 0xDEADBE7F.
- Handshake edges:
  - Hold MOV high 5 cycles past MOC -> MOC stays high, no second access.
  - Drop MOV mid-BUSY -> access completes; MOC high exactly 1 cycle.
  - Address 0x210 read -> same data as 0x010.
- Reset mid-operation: sw 0x12345678 to 0x20, assert reset during BUSY -> after reset, lw 0x20 returns its prior contents (e.g. 0x00000000 if preloaded 0); MOC=0 throughout reset.
